// File: rtl/snake_pkg.sv
// snake_pkg: shared direction/state encodings and the grid step helper for the snake body sequencer.
package snake_pkg;
  localparam int GRID_BITS = 4;
  localparam logic [2*GRID_BITS-1:0] HEAD_RST = 8'h88;
  typedef enum logic [1:0] {DIR_UP, DIR_RIGHT, DIR_DOWN, DIR_LEFT} dir_e;
  typedef enum logic [2:0] {ST_INIT, ST_IDLE, ST_TAIL, ST_MOVE, ST_SCAN, ST_DEAD} state_e;
  function automatic logic [2*GRID_BITS-1:0] step_xy(input logic [2*GRID_BITS-1:0] xy, input dir_e d);
    logic [GRID_BITS-1:0] x;
    logic [GRID_BITS-1:0] y;
    x = xy[2*GRID_BITS-1:GRID_BITS];
    y = xy[GRID_BITS-1:0];
    x = d == DIR_RIGHT ? x + 1'b1 : d == DIR_LEFT ? x - 1'b1 : x;
    y = d == DIR_DOWN ? y + 1'b1 : d == DIR_UP ? y - 1'b1 : y;
    return {x, y};
  endfunction
endpackage

// File: rtl/snake_body_ram.sv
// snake_body_ram: circular body store, synchronous write and registered (1-cycle) read, contents not reset.
module snake_body_ram
  import snake_pkg::*;
#(
  parameter int AW = 7
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [AW-1:0]            wr_addr,
  input  logic [2*GRID_BITS-1:0]   wr_data,
  input  logic [AW-1:0]            rd_addr,
  output logic [2*GRID_BITS-1:0]   rd_data
);
  logic [2*GRID_BITS-1:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/snake_body_ctrl.sv
// snake_body_ctrl: advances the snake head each tick, retires or keeps the tail, and scans the body for self-collision.
module snake_body_ctrl
  import snake_pkg::*;
#(
  parameter int MEM_WIDTH = 7,
  parameter int INIT_LEN  = 3
) (
  input  logic               clk,
  input  logic               aclr,
  input  logic               tick,
  input  logic [1:0]         dir,
  input  logic               grow,
  output logic [7:0]         head_xy,
  output logic [7:0]         tail_xy,
  output logic               tail_vld,
  output logic               step_done,
  output logic               dead,
  output logic               busy,
  output logic [MEM_WIDTH:0] length
);
  localparam logic [MEM_WIDTH:0] FULL = 1'b1 << MEM_WIDTH;
  localparam logic [MEM_WIDTH:0] LEN0 = (MEM_WIDTH+1)'(INIT_LEN);
  state_e state, nxt;
  dir_e cur_dir, dir_q;
  logic tick_q, grow_pend, wr_en, hit, scan_last, init_last, can_grow;
  logic [MEM_WIDTH-1:0] rdptr, wrptr, rd_addr;
  logic [MEM_WIDTH:0] sc;
  logic [7:0] rd_data, new_head, init_xy, wr_data;

  assign new_head  = step_xy(head_xy, cur_dir);
  assign init_xy   = {4'(9 - INIT_LEN + int'(wrptr)), 4'd8};
  assign wr_en     = state == ST_INIT || state == ST_MOVE;
  assign wr_data   = state == ST_INIT ? init_xy : new_head;
  assign rd_addr   = rdptr + sc[MEM_WIDTH-1:0];
  assign init_last = wrptr == MEM_WIDTH'(INIT_LEN - 1);
  assign can_grow  = grow_pend && length < FULL;
  // sc==0 holds a stale read from MOVE; entry k-1 is compared while sc==k
  assign hit       = sc != '0 && rd_data == head_xy;
  assign scan_last = sc == length - 1'b1;
  assign busy      = state != ST_IDLE && state != ST_DEAD;

  snake_body_ram #(.AW(MEM_WIDTH)) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wrptr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) state <= aclr ? ST_INIT : nxt;

  always_comb begin
    nxt = state;
    case (state)
      ST_INIT: nxt = init_last ? ST_IDLE : ST_INIT;
      ST_IDLE: nxt = tick_q ? ST_TAIL : ST_IDLE;
      ST_TAIL: nxt = ST_MOVE;
      ST_MOVE: nxt = ST_SCAN;
      ST_SCAN: nxt = hit ? ST_DEAD : scan_last ? ST_IDLE : ST_SCAN;
      default: nxt = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (aclr) begin
      head_xy   <= HEAD_RST;
      tail_xy   <= '0;
      tail_vld  <= 1'b0;
      step_done <= 1'b0;
      dead      <= 1'b0;
      length    <= LEN0;
      cur_dir   <= DIR_RIGHT;
      dir_q     <= DIR_RIGHT;
      tick_q    <= 1'b0;
      grow_pend <= 1'b0;
      rdptr     <= '0;
      wrptr     <= '0;
      sc        <= '0;
    end else begin
      tail_vld  <= 1'b0;
      step_done <= 1'b0;
      // only an idle tick is latched; one already pending blocks a second
      tick_q    <= tick && state == ST_IDLE && !tick_q;
      if (tick) dir_q <= dir_e'(dir);
      grow_pend <= (grow && state != ST_DEAD) || (grow_pend && state != ST_MOVE);
      case (state)
        ST_INIT: wrptr <= wrptr + 1'b1;
        ST_IDLE: if (tick_q && dir_q != (cur_dir ^ 2'd2)) cur_dir <= dir_q;
        ST_MOVE: begin
          head_xy <= new_head;
          wrptr   <= wrptr + 1'b1;
          if (can_grow) length <= length + 1'b1;
          else begin
            tail_xy  <= rd_data;
            tail_vld <= 1'b1;
            rdptr    <= rdptr + 1'b1;
          end
        end
        ST_SCAN: begin
          sc        <= (hit || scan_last) ? '0 : sc + 1'b1;
          dead      <= hit;
          step_done <= hit || scan_last;
        end
        default: ;
      endcase
    end
  end
endmodule
